// File: rtl/fp_pkg.sv
// Shared binary32 constants, operand record and classification helper
// for the FPU execution units.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Denormals (exp == 0) are treated as zero regardless of fraction.
    function automatic fp_class_t fp_classify(input fp32_t x);
        fp_class_t cls;
        if (x.exp == 8'd0) begin
            cls = ZERO;
        end else if (x.exp == 8'(EXP_MAX)) begin
            if (x.frac == 23'd0) begin
                cls = INF;
            end else begin
                cls = NAN;
            end
        end else begin
            cls = NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// 28-bit leading-zero counter used to normalise the add/sub significand.
// An all-zero input reports 28.
module fp_lzc (
    input  logic [27:0] value,
    output logic [4:0]  count
);

    // Highest set bit wins because the scan runs from LSB upwards.
    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            count = value[i] ? 5'(27 - i) : count;
        end
    end

endmodule

// File: rtl/fp_add_sub_unit.sv
// binary32 add/subtract unit, round-to-nearest-even, denormals flushed to zero.
// Define FP_ADD_SUB_IN_REG_EN to add an input register stage (latency 2).
module fp_add_sub_unit
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] opd1,
    input  logic [31:0] opd2,
    input  logic        op,
    output logic [31:0] res,
    output logic        exp_overflow_flag,
    output logic        exp_underflow_flag,
    output logic        nan_flag,
    output logic        zero_flag
);

    logic [31:0] a_in_s;
    logic [31:0] b_in_s;
    logic        op_in_s;

`ifdef FP_ADD_SUB_IN_REG_EN
    logic [31:0] a_in_r;
    logic [31:0] b_in_r;
    logic        op_in_r;

    // Optional operand capture stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_in_r  <= 32'd0;
            b_in_r  <= 32'd0;
            op_in_r <= 1'b0;
        end else begin
            a_in_r  <= opd1;
            b_in_r  <= opd2;
            op_in_r <= op;
        end
    end

    assign a_in_s  = a_in_r;
    assign b_in_s  = b_in_r;
    assign op_in_s = op_in_r;
`else
    assign a_in_s  = opd1;
    assign b_in_s  = opd2;
    assign op_in_s = op;
`endif

    fp32_t       a_s, b_s, big_s, small_s;
    fp_class_t   cls_a_s, cls_b_s;
    logic [7:0]  exp_diff_s;
    logic [26:0] sig_big_s, sig_small_s, aligned_s, shifted_s, lost_s;
    logic [27:0] sum_s;
    logic [4:0]  lz_s, lsh_s;
    logic [26:0] norm_s;
    logic        inc_s;
    logic [24:0] rnd_s;
    logic [22:0] frac_fin_s;
    logic signed [9:0] exp_norm_s, exp_fin_s;

    logic [31:0] res_s, res_r;
    logic        ovf_s, unf_s, nan_s, zero_s;
    logic        ovf_r, unf_r, nan_r, zero_r;

    fp_lzc u_lzc (
        .value (sum_s),
        .count (lz_s)
    );

    // Operand classification, magnitude swap, alignment and significand add.
    always_comb begin
        a_s      = fp32_t'(a_in_s);
        b_s      = fp32_t'({b_in_s[31] ^ op_in_s, b_in_s[30:0]});
        cls_a_s  = fp_classify(a_s);
        cls_b_s  = fp_classify(b_s);

        if ({b_s.exp, b_s.frac} > {a_s.exp, a_s.frac}) begin
            big_s   = b_s;
            small_s = a_s;
        end else begin
            big_s   = a_s;
            small_s = b_s;
        end

        exp_diff_s  = big_s.exp - small_s.exp;
        sig_big_s   = {1'b1, big_s.frac, 3'b000};
        sig_small_s = {1'b1, small_s.frac, 3'b000};
        shifted_s   = sig_small_s >> exp_diff_s[4:0];
        lost_s      = sig_small_s << (5'd27 - exp_diff_s[4:0]);

        // Anything shifted past the sticky position only contributes stickiness.
        if (exp_diff_s >= 8'd26) begin
            aligned_s = 27'd1;
        end else begin
            aligned_s = shifted_s | {26'd0, |lost_s};
        end

        if (big_s.sign ^ small_s.sign) begin
            sum_s = {1'b0, sig_big_s} - {1'b0, aligned_s};
        end else begin
            sum_s = {1'b0, sig_big_s} + {1'b0, aligned_s};
        end
    end

    // Normalisation, rounding and exponent adjustment.
    always_comb begin
        lsh_s = lz_s - 5'd1;
        if (sum_s[27]) begin
            norm_s     = sum_s[27:1] | {26'd0, sum_s[0]};
            exp_norm_s = $signed({2'b00, big_s.exp}) + 10'sd1;
        end else begin
            norm_s     = sum_s[26:0] << lsh_s;
            exp_norm_s = $signed({2'b00, big_s.exp}) - $signed({5'd0, lsh_s});
        end

        inc_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        rnd_s = {1'b0, norm_s[26:3]} + {24'd0, inc_s};

        if (rnd_s[24]) begin
            frac_fin_s = rnd_s[23:1];
            exp_fin_s  = exp_norm_s + 10'sd1;
        end else begin
            frac_fin_s = rnd_s[22:0];
            exp_fin_s  = exp_norm_s;
        end
    end

    // Result and flag selection, specials taking priority over the normal path.
    always_comb begin
        res_s  = 32'd0;
        ovf_s  = 1'b0;
        unf_s  = 1'b0;
        nan_s  = 1'b0;
        zero_s = 1'b0;
        if (cls_a_s == NAN || cls_b_s == NAN) begin
            res_s = QNAN;
            nan_s = 1'b1;
        end else if (cls_a_s == INF && cls_b_s == INF) begin
            if (a_s.sign != b_s.sign) begin
                res_s = QNAN;
                nan_s = 1'b1;
            end else begin
                res_s = {a_s.sign, POS_INF[30:0]};
            end
        end else if (cls_a_s == INF) begin
            res_s = {a_s.sign, POS_INF[30:0]};
        end else if (cls_b_s == INF) begin
            res_s = {b_s.sign, POS_INF[30:0]};
        end else if (cls_a_s == ZERO && cls_b_s == ZERO) begin
            res_s  = {a_s.sign & b_s.sign, 31'd0};
            zero_s = 1'b1;
        end else if (cls_a_s == ZERO) begin
            res_s = b_s;
        end else if (cls_b_s == ZERO) begin
            res_s = a_s;
        end else if (sum_s == 28'd0) begin
            res_s  = 32'd0;
            zero_s = 1'b1;
        end else if (exp_fin_s >= $signed(10'(EXP_MAX))) begin
            res_s = {big_s.sign, POS_INF[30:0]};
            ovf_s = 1'b1;
        end else if (exp_fin_s <= 10'sd0) begin
            res_s  = {big_s.sign, 31'd0};
            unf_s  = 1'b1;
            zero_s = 1'b1;
        end else begin
            res_s = {big_s.sign, exp_fin_s[7:0], frac_fin_s};
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_r  <= 32'd0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            nan_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            res_r  <= res_s;
            ovf_r  <= ovf_s;
            unf_r  <= unf_s;
            nan_r  <= nan_s;
            zero_r <= zero_s;
        end
    end

    assign res                = res_r;
    assign exp_overflow_flag  = ovf_r;
    assign exp_underflow_flag = unf_r;
    assign nan_flag           = nan_r;
    assign zero_flag          = zero_r;

endmodule

// File: tb/tb_fp_add_sub_unit.sv
// Scoreboard bench for fp_add_sub_unit: directed vectors with hand-computed
// results; a monitor pops expectations when their output cycle arrives.
module tb_fp_add_sub_unit;

`ifdef FP_ADD_SUB_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] opd1 = 32'd0;
    logic [31:0] opd2 = 32'd0;
    logic        op = 1'b0;
    logic [31:0] res;
    logic        exp_overflow_flag, exp_underflow_flag, nan_flag, zero_flag;

    fp_add_sub_unit dut (
        .clk                (clk),
        .rst                (rst),
        .opd1               (opd1),
        .opd2               (opd2),
        .op                 (op),
        .res                (res),
        .exp_overflow_flag  (exp_overflow_flag),
        .exp_underflow_flag (exp_underflow_flag),
        .nan_flag           (nan_flag),
        .zero_flag          (zero_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flags;   // {ovf, unf, nan, zero}
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    // Monitor: one output per posedge, compared against any expectation due now.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            tests = tests + 1;
            if (e.due < cyc) begin
                fails = fails + 1;
                $display("FAIL %s: expectation missed (due %0d, now %0d)", e.name, e.due, cyc);
            end else if ({res, exp_overflow_flag, exp_underflow_flag, nan_flag, zero_flag}
                         !== {e.res, e.flags}) begin
                fails = fails + 1;
                $display("FAIL %s: got res=%h flags=%b, expected res=%h flags=%b",
                         e.name, res,
                         {exp_overflow_flag, exp_underflow_flag, nan_flag, zero_flag},
                         e.res, e.flags);
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] a, input logic o,
                         input logic [31:0] b, input logic [31:0] r, input logic [3:0] f);
        exp_t e;
        opd1 = a;
        opd2 = b;
        op   = o;
        e.name  = name;
        e.res   = r;
        e.flags = f;
        e.due   = cyc + LAT;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic reset_cycle(input string name);
        exp_t e;
        rst = 1'b1;
        opd1 = 32'h4000_0000;
        opd2 = 32'h4000_0000;
        op   = 1'b0;
        e.name  = name;
        e.res   = 32'd0;
        e.flags = 4'b0000;
        e.due   = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        reset_cycle("reset_state");
        idle(LAT);

        issue("add_1_2",        32'h3F80_0000, 1'b0, 32'h4000_0000, 32'h4040_0000, 4'b0000);
        issue("sub_1_2",        32'h3F80_0000, 1'b1, 32'h4000_0000, 32'hBF80_0000, 4'b0000);
        issue("cancel",         32'h3F80_0000, 1'b1, 32'h3F80_0000, 32'h0000_0000, 4'b0001);
        issue("negz_negz",      32'h8000_0000, 1'b0, 32'h8000_0000, 32'h8000_0000, 4'b0001);
        issue("overflow",       32'h7F7F_FFFF, 1'b0, 32'h7F7F_FFFF, 32'h7F80_0000, 4'b1000);
        issue("neg_overflow",   32'hFF7F_FFFF, 1'b0, 32'hFF7F_FFFF, 32'hFF80_0000, 4'b1000);
        issue("rnd_overflow",   32'h7F7F_FFFF, 1'b0, 32'h7300_0000, 32'h7F80_0000, 4'b1000);
        issue("inf_minus_inf",  32'h7F80_0000, 1'b1, 32'h7F80_0000, 32'h7FC0_0000, 4'b0010);
        issue("nan_in",         32'h7FC0_1234, 1'b0, 32'h3F80_0000, 32'h7FC0_0000, 4'b0010);
        issue("tie_even",       32'h3F80_0000, 1'b0, 32'h3380_0000, 32'h3F80_0000, 4'b0000);
        issue("tie_up",         32'h3F80_0001, 1'b0, 32'h3380_0000, 32'h3F80_0002, 4'b0000);
        issue("underflow",      32'h0080_0001, 1'b1, 32'h0080_0000, 32'h0000_0000, 4'b0101);
        issue("inf_plus_fin",   32'h7F80_0000, 1'b0, 32'h3F80_0000, 32'h7F80_0000, 4'b0000);
        issue("sub_neg_inf",    32'h3F80_0000, 1'b1, 32'hFF80_0000, 32'h7F80_0000, 4'b0000);
        issue("zero_minus_b",   32'h0000_0000, 1'b1, 32'h3F80_0000, 32'hBF80_0000, 4'b0000);
        issue("a_plus_zero",    32'h4040_0000, 1'b0, 32'h0000_0000, 32'h4040_0000, 4'b0000);
        issue("denorm_flush",   32'h0000_0001, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'b0001);
        issue("carry_norm",     32'h3FC0_0000, 1'b0, 32'h3FC0_0000, 32'h4040_0000, 4'b0000);
        issue("sub_2_1",        32'h4000_0000, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);
        issue("deep_cancel",    32'h3F80_0000, 1'b0, 32'hBF7F_FFFF, 32'h3380_0000, 4'b0000);

        idle(LAT);
        reset_cycle("mid_reset");
        issue("after_reset",    32'h4040_0000, 1'b0, 32'hBF80_0000, 32'h4000_0000, 4'b0000);
        issue("after_reset2",   32'h3F80_0000, 1'b0, 32'h4000_0000, 32'h4040_0000, 4'b0000);

        idle(LAT + 2);
        if (q.size() != 0) begin
            fails = fails + 1;
            tests = tests + 1;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
